sliding_window_agg: RTL and testbench

- Parametrised event-fed sliding-window aggregator for the monitor's sliding-window streams.
- Each `in_valid` event folds into an open bucket. A `tick` from the HLC schedule closes that bucket into a ring of NUM_BUCKETS buckets.
- After each tick, a multi-cycle scan produces the window's sum, count, min and max.
- Generalises the fixed sum-only window with configurable width, depth and saturation, plus warm-up, empty and overrun flags.

---
 rtl/sw_agg_pkg.sv | 38 +++
 rtl/sw_bucket_ring.sv | 51 +++++
 rtl/sliding_window_agg.sv | 170 +++++++++++++++++
 tb/tb_sliding_window_agg.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sw_agg_pkg.sv
// Shared types and saturating arithmetic for the sliding-window aggregator.
// The helpers work on a wide intermediate, so ACC_W up to 126 and CNT_W up to 63 are supported.
`timescale 1ns/1ps
package sw_agg_pkg;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    localparam int SAT_W = 128;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Signed add clamped to the w-bit two's-complement range.
    function automatic logic signed [SAT_W-1:0] sat_add_s(input logic signed [SAT_W-1:0] a,
                                                          input logic signed [SAT_W-1:0] b,
                                                          input int w);
        logic signed [SAT_W-1:0] s;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        s  = a + b;
        hi = ({{(SAT_W-1){1'b0}}, 1'b1} << (w - 1)) - 1;
        lo = -hi - 1;
        if (s > hi)
            return hi;
        else if (s < lo)
            return lo;
        return s;
    endfunction

    // Unsigned increment that sticks at 2^w-1.
    function automatic logic [63:0] sat_inc_u(input logic [63:0] c, input int w);
        logic [63:0] lim;
        lim = (64'd1 << w) - 64'd1;
        return (c >= lim) ? lim : c + 64'd1;
    endfunction

endpackage

// File: rtl/sw_bucket_ring.sv
// Ring of committed buckets: commit writes the oldest slot, the scan reads any slot by index.
// win_full rises once NUM_BUCKETS commits have landed since reset.
`timescale 1ns/1ps
module sw_bucket_ring
    import sw_agg_pkg::*;
#(
    parameter int  NUM_BUCKETS = 4,
    parameter type bucket_t    = logic [7:0]
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               commit,
    input  bucket_t                            wr_data,
    input  logic [idx_width(NUM_BUCKETS)-1:0]  rd_idx,
    output bucket_t                            rd_data,
    output logic                               win_full
);
    localparam int IDX_W  = idx_width(NUM_BUCKETS);
    localparam int FULL_W = $clog2(NUM_BUCKETS + 1);

    bucket_t                ring_reg [NUM_BUCKETS];
    logic [IDX_W-1:0]       wr_ptr_reg;
    logic [FULL_W-1:0]      commits_reg;
    logic [NUM_BUCKETS-1:0] wr_en;

    for (genvar gi = 0; gi < NUM_BUCKETS; gi++) begin : g_wr_en
        assign wr_en[gi] = commit && (wr_ptr_reg == IDX_W'(gi));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_BUCKETS; i++)
                ring_reg[i] <= '0;
            wr_ptr_reg  <= '0;
            commits_reg <= '0;
        end else begin
            for (int i = 0; i < NUM_BUCKETS; i++)
                if (wr_en[i])
                    ring_reg[i] <= wr_data;
            if (commit) begin
                wr_ptr_reg <= (wr_ptr_reg == IDX_W'(NUM_BUCKETS - 1)) ? '0 : wr_ptr_reg + 1'b1;
                if (commits_reg != FULL_W'(NUM_BUCKETS))
                    commits_reg <= commits_reg + 1'b1;
            end
        end
    end

    assign rd_data  = ring_reg[rd_idx];
    assign win_full = (commits_reg == FULL_W'(NUM_BUCKETS));

endmodule

// File: rtl/sliding_window_agg.sv
// Event-fed sliding-window aggregator: events fold into an open bucket, each tick commits it
// to the ring and launches a one-entry-per-cycle scan producing sum, count, min and max.
`timescale 1ns/1ps
module sliding_window_agg
    import sw_agg_pkg::*;
#(
    parameter int DATA_W      = 64,
    parameter int NUM_BUCKETS = 4,
    parameter int CNT_W       = 16,
    parameter int ACC_W       = 72
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     en,
    input  logic signed [DATA_W-1:0]                 in_data,
    input  logic                                     in_valid,
    input  logic                                     tick,
    output logic                                     out_valid,
    output logic signed [ACC_W-1:0]                  out_sum,
    output logic [CNT_W+$clog2(NUM_BUCKETS)-1:0]     out_count,
    output logic signed [DATA_W-1:0]                 out_min,
    output logic signed [DATA_W-1:0]                 out_max,
    output logic                                     out_empty,
    output logic                                     win_full,
    output logic                                     busy,
    output logic                                     overrun
);
    localparam int IDX_W  = idx_width(NUM_BUCKETS);
    localparam int WCNT_W = CNT_W + $clog2(NUM_BUCKETS);

    typedef struct packed {
        logic signed [ACC_W-1:0]  sum;
        logic [CNT_W-1:0]         count;
        logic signed [DATA_W-1:0] min;
        logic signed [DATA_W-1:0] max;
    } bucket_t;

    state_t                   state_reg, state_next;
    bucket_t                  open_reg, open_next, ring_rd;
    logic [IDX_W-1:0]         idx_reg;
    logic signed [ACC_W-1:0]  acc_sum_reg, scan_sum;
    logic [WCNT_W-1:0]        acc_cnt_reg, scan_cnt;
    logic signed [DATA_W-1:0] acc_min_reg, acc_max_reg, scan_min, scan_max;
    logic                     valid_reg, overrun_reg;
    logic                     last_idx;

    assign busy     = (state_reg != IDLE);
    assign last_idx = (idx_reg == IDX_W'(NUM_BUCKETS - 1));

    sw_bucket_ring #(
        .NUM_BUCKETS (NUM_BUCKETS),
        .bucket_t    (bucket_t)
    ) u_ring (
        .clk      (clk),
        .rst      (rst),
        .commit   (en && tick),
        .wr_data  (open_reg),
        .rd_idx   (idx_reg),
        .rd_data  (ring_rd),
        .win_full (win_full)
    );

    // A tick always (re)starts the scan, even mid-scan, so an interrupted result is discarded.
    always_comb begin
        state_next = state_reg;
        if (en) begin
            if (tick)
                state_next = SCAN;
            else begin
                case (state_reg)
                    SCAN:    if (last_idx) state_next = DONE;
                    DONE:    state_next = IDLE;
                    default: state_next = state_reg;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    // An event arriving with the tick seeds the new bucket rather than the committed one.
    always_comb begin
        open_next = open_reg;
        if (tick) begin
            open_next = '0;
            if (in_valid) begin
                open_next.sum   = ACC_W'(in_data);
                open_next.count = CNT_W'(1);
                open_next.min   = in_data;
                open_next.max   = in_data;
            end
        end else if (in_valid) begin
            open_next.sum   = ACC_W'(sat_add_s(SAT_W'(open_reg.sum), SAT_W'(in_data), ACC_W));
            open_next.count = CNT_W'(sat_inc_u(64'(open_reg.count), CNT_W));
            if (open_reg.count == '0 || in_data < open_reg.min)
                open_next.min = in_data;
            if (open_reg.count == '0 || in_data > open_reg.max)
                open_next.max = in_data;
        end
    end

    // Empty buckets contribute nothing to min/max; the first non-empty one seeds them.
    always_comb begin
        scan_sum = ACC_W'(sat_add_s(SAT_W'(acc_sum_reg), SAT_W'(ring_rd.sum), ACC_W));
        scan_cnt = acc_cnt_reg + WCNT_W'(ring_rd.count);
        scan_min = acc_min_reg;
        scan_max = acc_max_reg;
        if (ring_rd.count != '0) begin
            if (acc_cnt_reg == '0 || ring_rd.min < acc_min_reg)
                scan_min = ring_rd.min;
            if (acc_cnt_reg == '0 || ring_rd.max > acc_max_reg)
                scan_max = ring_rd.max;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            open_reg    <= '0;
            idx_reg     <= '0;
            acc_sum_reg <= '0;
            acc_cnt_reg <= '0;
            acc_min_reg <= '0;
            acc_max_reg <= '0;
            out_sum     <= '0;
            out_count   <= '0;
            out_min     <= '0;
            out_max     <= '0;
            out_empty   <= 1'b0;
            valid_reg   <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            valid_reg   <= 1'b0;
            overrun_reg <= 1'b0;
            if (en) begin
                open_reg <= open_next;
                if (tick) begin
                    overrun_reg <= busy;
                    idx_reg     <= '0;
                    acc_sum_reg <= '0;
                    acc_cnt_reg <= '0;
                    acc_min_reg <= '0;
                    acc_max_reg <= '0;
                end else if (state_reg == SCAN) begin
                    acc_sum_reg <= scan_sum;
                    acc_cnt_reg <= scan_cnt;
                    acc_min_reg <= scan_min;
                    acc_max_reg <= scan_max;
                    if (!last_idx)
                        idx_reg <= idx_reg + 1'b1;
                end else if (state_reg == DONE) begin
                    out_sum   <= acc_sum_reg;
                    out_count <= acc_cnt_reg;
                    out_min   <= acc_min_reg;
                    out_max   <= acc_max_reg;
                    out_empty <= (acc_cnt_reg == '0);
                    valid_reg <= 1'b1;
                end
            end
        end
    end

    assign out_valid = valid_reg && en;
    assign overrun   = overrun_reg && en;

endmodule

// File: tb/tb_sliding_window_agg.sv
// Scoreboard bench: stimulus feeds a list-based window model that queues expected results;
// a negedge monitor pops and compares each out_valid and every overrun pulse.
`timescale 1ns/1ps
module tb_sliding_window_agg;
    localparam int DATA_W = 8;
    localparam int NB     = 4;
    localparam int CNT_W  = 4;
    localparam int ACC_W  = 8;
    localparam int OCW    = CNT_W + $clog2(NB);
    localparam int SMAX   = 127;
    localparam int SMIN   = -128;
    localparam int CMAX   = 15;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     en = 1'b0;
    logic                     in_valid = 1'b0;
    logic                     tick = 1'b0;
    logic signed [DATA_W-1:0] in_data = '0;
    logic                     out_valid;
    logic signed [ACC_W-1:0]  out_sum;
    logic [OCW-1:0]           out_count;
    logic signed [DATA_W-1:0] out_min, out_max;
    logic                     out_empty, win_full, busy, overrun;

    always #5 clk = ~clk;

    sliding_window_agg #(
        .DATA_W(DATA_W), .NUM_BUCKETS(NB), .CNT_W(CNT_W), .ACC_W(ACC_W)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .in_data(in_data), .in_valid(in_valid), .tick(tick),
        .out_valid(out_valid), .out_sum(out_sum), .out_count(out_count), .out_min(out_min),
        .out_max(out_max), .out_empty(out_empty), .win_full(win_full), .busy(busy),
        .overrun(overrun)
    );

    typedef struct { int sum; int cnt; int mn; int mx; } bkt_t;
    typedef struct { int sum; int cnt; int mn; int mx; int empty; int full; } res_t;

    res_t exp_q[$];
    bkt_t m_ring[NB];
    int   m_open[$];
    int   m_commits = 0;
    int   en_edges = 0;
    int   due = 0;
    bit   pending = 1'b0;
    bit   ov_expect = 1'b0;
    res_t pend_res;
    int   errors = 0;
    int   checks = 0;
    int   txns = 0;

    function automatic int clamp(input int v);
        return (v > SMAX) ? SMAX : (v < SMIN) ? SMIN : v;
    endfunction

    // Bucket contents follow from the raw list of events it received.
    function automatic bkt_t close_open();
        bkt_t b;
        b.sum = 0; b.cnt = 0; b.mn = 0; b.mx = 0;
        foreach (m_open[i]) begin
            b.sum = clamp(b.sum + m_open[i]);
            if (i == 0 || m_open[i] < b.mn) b.mn = m_open[i];
            if (i == 0 || m_open[i] > b.mx) b.mx = m_open[i];
        end
        b.cnt = (m_open.size() > CMAX) ? CMAX : m_open.size();
        return b;
    endfunction

    function automatic res_t window_of();
        res_t r;
        r.sum = 0; r.cnt = 0; r.mn = 0; r.mx = 0;
        for (int s = 0; s < NB; s++) begin
            r.sum = clamp(r.sum + m_ring[s].sum);
            if (m_ring[s].cnt > 0) begin
                if (r.cnt == 0 || m_ring[s].mn < r.mn) r.mn = m_ring[s].mn;
                if (r.cnt == 0 || m_ring[s].mx > r.mx) r.mx = m_ring[s].mx;
                r.cnt += m_ring[s].cnt;
            end
        end
        r.empty = (r.cnt == 0) ? 1 : 0;
        r.full  = (m_commits >= NB) ? 1 : 0;
        return r;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < NB; s++) begin
            m_ring[s].sum = 0; m_ring[s].cnt = 0; m_ring[s].mn = 0; m_ring[s].mx = 0;
        end
        m_open.delete();
        m_commits = 0;
        pending   = 1'b0;
        ov_expect = 1'b0;
    endtask

    task automatic model_edge(input bit v, input int d, input bit t, input bit e);
        ov_expect = 1'b0;
        if (!e) return;
        en_edges++;
        if (t) begin
            ov_expect = pending;
            m_ring[m_commits % NB] = close_open();
            m_commits++;
            m_open.delete();
            if (v) m_open.push_back(d);
            pend_res = window_of();
            pending  = 1'b1;
            due      = en_edges + NB + 1;
        end else begin
            if (v) m_open.push_back(d);
            if (pending && en_edges == due) begin
                exp_q.push_back(pend_res);
                pending = 1'b0;
            end
        end
    endtask

    task automatic step(input bit v, input int d, input bit t, input bit e);
        logic signed [DATA_W-1:0] d8;
        d8 = DATA_W'(d);
        in_valid = v; in_data = d8; tick = t; en = e;
        @(posedge clk);
        model_edge(v, int'(d8), t, e);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 1'b1);
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic check_held(input string tag, input int s, input int c, input int mn,
                              input int mx, input int em, input int fu);
        chk({tag, ".sum"},   int'(out_sum), s);
        chk({tag, ".count"}, int'(out_count), c);
        chk({tag, ".min"},   int'(out_min), mn);
        chk({tag, ".max"},   int'(out_max), mx);
        chk({tag, ".empty"}, int'(out_empty), em);
        chk({tag, ".full"},  int'(win_full), fu);
    endtask

    task automatic check_all_zero(input string tag);
        check_held(tag, 0, 0, 0, 0, 0, 0);
        chk({tag, ".busy"},      int'(busy), 0);
        chk({tag, ".out_valid"}, int'(out_valid), 0);
        chk({tag, ".overrun"},   int'(overrun), 0);
    endtask

    task automatic tick_and_wait();
        step(1'b0, 0, 1'b1, 1'b1);
        idle(NB + 3);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (overrun || ov_expect)
                chk("overrun", int'(overrun), int'(ov_expect));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_out_valid: got sum=%0d count=%0d, expected no result",
                             out_sum, out_count);
                end else begin
                    res_t r;
                    r = exp_q.pop_front();
                    txns++;
                    $display("txn %0d: sum=%0d count=%0d min=%0d max=%0d empty=%0b full=%0b",
                             txns, out_sum, out_count, out_min, out_max, out_empty, win_full);
                    chk("sb.sum",   int'(out_sum), r.sum);
                    chk("sb.count", int'(out_count), r.cnt);
                    chk("sb.min",   int'(out_min), r.mn);
                    chk("sb.max",   int'(out_max), r.mx);
                    chk("sb.empty", int'(out_empty), r.empty);
                    chk("sb.full",  int'(win_full), r.full);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int w;
        model_reset();
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        idle(10);
        check_all_zero("reset");

        tick_and_wait();
        check_held("empty_win", 0, 0, 0, 0, 1, 0);

        step(1'b1, 1, 1'b0, 1'b1);
        tick_and_wait();
        check_held("warmup", 1, 1, 1, 1, 0, 0);

        for (int a = 1; a <= 10; a++) begin
            step(1'b1, a, 1'b0, 1'b1);
            tick_and_wait();
            if (a == 4)  check_held("steady4", 10, 4, 1, 4, 0, 1);
            if (a == 5)  check_held("steady5", 14, 4, 2, 5, 0, 1);
            if (a == 10) check_held("steady10", 34, 4, 7, 10, 0, 1);
        end

        step(1'b1, 7, 1'b1, 1'b1);
        idle(NB + 3);
        check_held("simul_excl", 27, 3, 8, 10, 0, 1);
        tick_and_wait();
        check_held("simul_incl", 26, 3, 7, 10, 0, 1);

        t0 = txns;
        step(1'b1, 3, 1'b0, 1'b1);
        step(1'b0, 0, 1'b1, 1'b1);
        step(1'b1, 4, 1'b0, 1'b1);
        step(1'b0, 0, 1'b1, 1'b1);
        idle(NB + 4);
        chk("busy_tick_results", txns - t0, 1);
        check_held("busy_tick", 14, 3, 3, 7, 0, 1);

        for (int i = 0; i < NB; i++) tick_and_wait();
        check_held("flushed", 0, 0, 0, 0, 1, 1);

        step(1'b1, 100, 1'b0, 1'b1);
        step(1'b1, 100, 1'b0, 1'b1);
        step(1'b1, -5, 1'b0, 1'b1);
        tick_and_wait();
        check_held("sat", 122, 3, -5, 100, 0, 1);

        step(1'b1, 50, 1'b0, 1'b0);
        step(1'b0, 0, 1'b1, 1'b0);
        tick_and_wait();
        check_held("en_low", 122, 3, -5, 100, 0, 1);

        for (int b = 0; b < 30; b++) begin
            int gap;
            gap = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 5) : $urandom_range(6, 40);
            for (int g = 0; g < gap; g++)
                step(1'($urandom_range(0, 1)), $urandom_range(0, 255), 1'b0, 1'b1);
            step(1'($urandom_range(0, 1)), $urandom_range(0, 255), 1'b1, 1'b1);
        end

        w = 0;
        while ((pending || exp_q.size() != 0) && w < 40) begin
            idle(1);
            w++;
        end
        chk("drain_outstanding", int'(pending) + exp_q.size(), 0);

        step(1'b1, 9, 1'b0, 1'b1);
        step(1'b0, 0, 1'b1, 1'b1);
        idle(2);
        #2 rst = 1'b0;
        model_reset();
        exp_q.delete();
        #1;
        check_all_zero("rst_mid_scan");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        idle(10);
        check_all_zero("after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
